// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller.
// Digit values are BCD nibbles limited to 0..9.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX = 4'd9;

  // Next value of a single BCD digit, wrapping 9 -> 0.
  function automatic digit_t bcd_inc(input digit_t d);
    return (d == BCD_MAX) ? 4'd0 : digit_t'(d + 4'd1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle count tick every TICK_DIV enabled cycles.
// The count holds while enable is low so a partial period resumes.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : CNT_W'(count + CNT_W'(1));
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Run/pause/lap sequencing for a chain of cascaded BCD digit counters,
// producing the packed BCD word for the seven-segment display path.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] display_bcd,
  output logic                    running,
  output logic                    lap_active,
  output logic                    overflow
);

  sw_state_t state, next_state;
  logic      clr_all;
  logic      lap_capture;
  logic      lap_release;
  logic      tick;

  digit_t [NUM_DIGITS-1:0] digits;
  digit_t [NUM_DIGITS-1:0] lap_reg;
  digit_t                  digit_nxt [NUM_DIGITS];
  logic   [NUM_DIGITS:0]   all_nine;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Accepted clear wins over everything; start_stop wins over lap.
  always_comb begin
    next_state  = state;
    clr_all     = 1'b0;
    lap_capture = 1'b0;
    lap_release = 1'b0;
    if (clear && (state != RUN)) begin
      clr_all    = 1'b1;
      next_state = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    next_state = RUN;
        RUN:     next_state = PAUSE;
        PAUSE:   next_state = RUN;
        default: next_state = IDLE;
      endcase
    end else if (lap) begin
      if ((state == RUN) && !lap_active) begin
        lap_capture = 1'b1;
      end else if ((state != IDLE) && lap_active) begin
        lap_release = 1'b1;
      end
    end
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr_all),
    .enable (state == RUN),
    .tick   (tick)
  );

  // Look-ahead carry: a digit advances when every lower digit is at 9.
  assign all_nine[0] = 1'b1;
  for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_digit
    assign all_nine[k+1] = all_nine[k] && (digits[k] == BCD_MAX);
    assign digit_nxt[k]  = all_nine[k] ? bcd_inc(digits[k]) : digits[k];
  end

  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      digits <= '0;
    end else if (tick) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        digits[k] <= digit_nxt[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      lap_reg    <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (lap_capture) begin
        lap_reg    <= digits;
        lap_active <= 1'b1;
      end else if (lap_release) begin
        lap_active <= 1'b0;
      end
      if (tick && all_nine[NUM_DIGITS]) begin
        overflow <= 1'b1;
      end
    end
  end

  assign display_bcd = lap_active ? lap_reg : digits;
  assign running     = (state == RUN);

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Sequencing controller for a chain of NUM_DIGITS BCD digit counters forming a stopwatch.
- A prescaler turns clk into a count tick.
- An IDLE/RUN/PAUSE FSM decides when the tick reaches the digit chain; lap and clear are also handled here.
- Feeds the seven-segment display path with packed BCD digits.

Parameters:
TICK_DIV, 50000, clk cycles per count tick (>=2); simulation uses 4
NUM_DIGITS, 4, number of cascaded BCD digits (>=1)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
start_stop  input  1  single-cycle pulse, toggles run/pause
lap  input  1  single-cycle pulse, toggles lap freeze of the display
clear  input  1  single-cycle pulse, zeroes the count when not running
display_bcd  output  4*NUM_DIGITS  displayed count, digit 0 (least significant) in bits [3:0]
running  output  1  high in RUN
lap_active  output  1  high while the display is frozen
overflow  output  1  sticky, set when the count wraps from all-9s

Behaviour:
Reset (reset=1 at a posedge):
- state=IDLE, prescaler=0, all digits=0, lap register=0.
- lap_active=0, overflow=0, running=0, display_bcd=0.
- Reset overrides every other input, including mid-RUN.

FSM (evaluated on each posedge, next state visible the following cycle):
- IDLE: start_stop -> RUN. clear -> stays IDLE and re-zeroes all state.
- RUN: start_stop -> PAUSE. clear is ignored.
- PAUSE: start_stop -> RUN. clear -> IDLE: digits, prescaler, overflow, lap_active and lap register all zeroed.
- Priority: an accepted clear (state != RUN) discards start_stop and lap in the same cycle. Otherwise start_stop beats lap: if both arrive together, lap is dropped.

Prescaler:
- Counts 0..TICK_DIV-1, incrementing only in RUN.
- tick=1 (internal, one cycle) when state==RUN and prescaler==TICK_DIV-1; prescaler returns to 0 on that edge.
- In PAUSE the prescaler holds its value, so the partial period resumes.
- First tick after IDLE->RUN falls on the TICK_DIV-th RUN cycle.

Digit chain:
- digit[0] enable = tick. digit[k] enable = tick AND digits[0..k-1] all == 9 (look-ahead carry, no ripple delay).
- An enabled digit at 9 goes to 0; otherwise it increments by 1. Digits never leave 0..9.
- All digits update on the same edge as tick (one-cycle latency from tick to new count).
- Tick with all digits == 9 wraps every digit to 0, sets overflow, and counting continues. overflow is cleared only by reset or an accepted clear.

Lap:
- In RUN, lap with lap_active=0: copies the live digits into the lap register and sets lap_active.
- lap with lap_active=1, in RUN or PAUSE: clears lap_active.
- lap in PAUSE with lap_active=0 does nothing; lap in IDLE is ignored.
- The live count keeps advancing while frozen.
- display_bcd = lap_active ? lap register : live digits. This is a combinational mux of registered values, with no added latency.

running is a combinational decode of state==RUN.

Decomposition:
- Package stopwatch_pkg: state enum (IDLE, RUN, PAUSE), BCD_MAX=4'd9, digit typedef logic [3:0].
- One natural sub-module, tick_prescaler (parameter TICK_DIV; ports clk, reset, clr, enable, tick).
- Digit chain and lap register are generate-loop logic inside stopwatch_controller.

Test Plan (TICK_DIV=4, NUM_DIGITS=4):
1. Basic count: reset, start_stop pulse, hold in RUN for 40 cycles -> display_bcd=16'h0010, running=1, overflow=0.
2. Carry: run to 16'h0099, next tick -> 16'h0100 on the edge with tick; no intermediate value such as 16'h0090 ever appears.
3. Wrap and clear: preload via run to 16'h9999, one tick -> 16'h0000 with overflow=1, still running. clear in RUN -> ignored. start_stop then clear -> IDLE, display 0, overflow=0.
4. Pause mid-period: start_stop when prescaler=2 -> PAUSE, 10 idle cycles with display unchanged. start_stop -> the next tick occurs on the 2nd RUN cycle, not the 4th.
5. Lap: lap at live 16'h0025 -> display holds 16'h0025 while live reaches 16'h0031. lap again -> display 16'h0031, lap_active=0.
6. Corner cases:
   - reset asserted mid-RUN at count 16'h0007 -> next cycle all outputs 0, state IDLE.
   - clear+start_stop together in PAUSE -> IDLE, running stays 0.
